// File: rtl/aes_stream_ctrl.sv
// Job sequencer for the AES HWPE 128-to-32-bit unstacker: admits a programmed number of
// blocks, counts emitted words, pulses done. Define AES_CTRL_TIMEOUT_EN to add the watchdog.
module aes_stream_ctrl #(
    parameter int unsigned NB_W           = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            start_i,
    input  logic [NB_W-1:0] nblocks_i,
    input  logic            src_valid_i,
    output logic            src_ready_o,
    output logic            blk_valid_o,
    input  logic            blk_ready_i,
    input  logic            word_valid_i,
    input  logic            word_ready_i,
    output logic            enable_o,
    output logic            clr_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [NB_W-1:0] blk_cnt_o,
    output logic [NB_W+1:0] word_cnt_o
);

    localparam int unsigned WC_W = NB_W + 2;

    // The watchdog compares against TIMEOUT_CYCLES-2, so smaller limits are meaningless.
    if (TIMEOUT_CYCLES < 2) begin : g_tmo_range
        $error("aes_stream_ctrl: TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e          state_q;
    logic [NB_W-1:0] nblocks_q;
    logic [NB_W-1:0] blk_cnt_q;
    logic [WC_W-1:0] word_cnt_q;
    logic            enable_q;
    logic            busy_q;
    logic            done_q;
    logic            clr_q;

    logic            gate_open;
    logic            blk_hs;
    logic            word_hs;
    logic            last_word;
    logic            timeout;
    logic [WC_W-1:0] last_word_idx;

    // Block gate is purely combinational so the stream sees no added latency.
    assign gate_open     = (state_q == RUN) && (blk_cnt_q < nblocks_q);
    assign blk_valid_o   = gate_open & src_valid_i;
    assign src_ready_o   = gate_open & blk_ready_i;
    assign blk_hs        = blk_valid_o & blk_ready_i;
    assign word_hs       = (state_q == RUN) & word_valid_i & word_ready_i;
    assign last_word_idx = {nblocks_q, 2'b00} - WC_W'(1);
    assign last_word     = word_hs && (word_cnt_q == last_word_idx);

`ifdef AES_CTRL_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [WD_W-1:0] wdog_q;
    logic            err_q;

    // Fires on the cycle the idle count would reach TIMEOUT_CYCLES-1.
    assign timeout = (state_q == RUN) && !blk_hs && !word_hs &&
                     (wdog_q == WD_W'(TIMEOUT_CYCLES - 2));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog_q <= '0;
        end else if (clr_i || (state_q != RUN) || blk_hs || word_hs) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (clr_i || ((state_q == IDLE) && start_i)) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    // Sequencer; flag registers are loaded with the values of the state being entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            nblocks_q  <= '0;
            blk_cnt_q  <= '0;
            word_cnt_q <= '0;
            enable_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            clr_q      <= 1'b0;
        end else if (clr_i) begin
            state_q    <= IDLE;
            blk_cnt_q  <= '0;
            word_cnt_q <= '0;
            enable_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            clr_q      <= 1'b0;
        end else begin
            enable_q <= 1'b0;
            done_q   <= 1'b0;
            clr_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        nblocks_q  <= nblocks_i;
                        blk_cnt_q  <= '0;
                        word_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        if (nblocks_i == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CLEAR;
                            clr_q   <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    state_q  <= RUN;
                    enable_q <= 1'b1;
                end
                RUN: begin
                    if (blk_hs) begin
                        blk_cnt_q <= blk_cnt_q + NB_W'(1);
                    end
                    if (word_hs) begin
                        word_cnt_q <= word_cnt_q + WC_W'(1);
                    end
                    if (last_word || timeout) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        enable_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign enable_o   = enable_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign clr_o      = clr_q | clr_i;
    assign blk_cnt_o  = blk_cnt_q;
    assign word_cnt_o = word_cnt_q;

endmodule

// File: doc/aes_stream_ctrl.md
# aes_stream_ctrl

Job sequencer for the 128-to-32-bit word unstacking stage of the AES HWPE datapath. It accepts a start command with a block count, issues the datapath clear and enable, and gates the upstream 128-bit block stream so that exactly the programmed number of blocks enters the unstacker. It counts the resulting 32-bit output words and signals completion to the HWPE controller once the last word of the job has been handed off.

## Interface
- NB_W, default 16: width of block count; max job = 2^NB_W-1 blocks.
- TIMEOUT_CYCLES, default 1024: watchdog limit, used only when AES_CTRL_TIMEOUT_EN is defined.

- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- clr_i  in  1  synchronous soft clear (abort).
- start_i  in  1  job start pulse.
- nblocks_i  in  NB_W  number of 128-bit blocks in job; sampled with start_i.
- src_valid_i  in  1  upstream block valid.
- src_ready_o  out  1  upstream block ready.
- blk_valid_o  out  1  gated block valid to unstacker.
- blk_ready_i  in  1  unstacker input ready.
- word_valid_i  in  1  unstacker output valid (observed only).
- word_ready_i  in  1  downstream ready for unstacker output (observed only).
- enable_o  out  1  datapath enable.
- clr_o  out  1  datapath clear.
- busy_o  out  1  job in progress.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  watchdog abort flag, sticky.
- blk_cnt_o  out  NB_W  blocks accepted in current job.
- word_cnt_o  out  NB_W+2  words emitted in current job.

## Operation
- States: IDLE, CLEAR, RUN, DONE. Reset: IDLE. Counters, latched nblocks and err_o reset to 0; all outputs reset to 0.
- IDLE: enable_o=0, busy_o=0, gate closed. A start_i with nblocks_i!=0 latches nblocks_i, zeroes the counters, clears err_o, and moves to CLEAR. A start_i with nblocks_i==0 moves directly to DONE with no clear and no enable.
- CLEAR: clr_o=1, busy_o=1, enable_o=0. Lasts one cycle, then moves to RUN.
- RUN: enable_o=1, busy_o=1.
  - Gate is open while blk_cnt < nblocks: blk_valid_o=src_valid_i and src_ready_o=blk_ready_i.
  - Gate is closed otherwise: both outputs 0.
  - blk_cnt increments on blk_valid_o & blk_ready_i.
  - word_cnt increments on word_valid_i & word_ready_i.
  - When a word handshake occurs with word_cnt==4*nblocks-1, the state moves to DONE.
- DONE: done_o=1, busy_o=1, enable_o=0, gate closed. Lasts one cycle, then moves to IDLE. Counters hold their final values until the next start.
- start_i outside IDLE is ignored.
- clr_i in any state: next state IDLE, counters zeroed, err_o cleared. clr_o=1 combinationally in that cycle. clr_i has priority over start_i.
- Arithmetic: 4*nblocks is computed as {nblocks,2'b00} in NB_W+2 bits, so it never overflows. Counters never wrap inside a legal job.
- A block handshake and a word handshake in the same cycle both count.

## Timing
- start_i high at cycle 0 in IDLE gives CLEAR at cycle 1 (clr_o=1) and RUN at cycle 2 (enable_o=1, gate open).
- The gate is combinational, with zero added latency from src_valid_i/blk_ready_i to blk_valid_o/src_ready_o.
- The last word handshake at cycle N gives done_o=1 at cycle N+1 and IDLE at cycle N+2. A new start is accepted at cycle N+2.
- A start with nblocks=0 at cycle 0 gives done_o at cycle 1.
- Minimum job overhead is 3 cycles: CLEAR, DONE, and the return to IDLE.

## Configuration
- AES_CTRL_TIMEOUT_EN defined:
  - A watchdog counter runs in RUN. It resets to 0 on any block or word handshake and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 without a handshake, the next state is DONE and err_o is set.
  - done_o still pulses. err_o stays set until the next start_i or clr_i.
- AES_CTRL_TIMEOUT_EN undefined: no watchdog logic. err_o is tied to 0 and TIMEOUT_CYCLES is ignored.

## Test plan
- Reset with all inputs idle: every output is 0 and blk_cnt_o=word_cnt_o=0.
- Start with nblocks=2, source always valid, all readies 1:
  - clr_o at cycle 1.
  - blk_cnt_o reaches 2.
  - Gate closes after 2 blocks.
  - word_cnt_o reaches 8.
  - done_o pulses exactly once, one cycle after the 8th word.
- Start with nblocks=0: done_o at cycle 1, clr_o and enable_o never assert.
- Start with nblocks=3 and random backpressure on blk_ready_i and word_ready_i: exactly 3 blocks are accepted, done_o follows word 12, and src_valid_i stays ignored afterwards.
- clr_i after 5 words of a 4-block job: clr_o=1 that cycle, the next state is IDLE, and the counters read 0. A second start_i issued while busy has no effect.
- With AES_CTRL_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, start with nblocks=1 and hold word_ready_i=0: done_o and err_o assert 16 cycles after the last handshake, and err_o clears on the next start.
